// File: rtl/router_rr_arbiter.sv
// router_rr_arbiter
//
// Output-port arbiter for a mesh router. Up to NPORTS input buffers (EAST,
// WEST, NORTH, SOUTH, LOCAL) compete for one output link. A winner keeps the
// link packet by packet. When other ports are waiting, a winner is forced to
// give up the link after INTERLEAVING_GRAIN owned cycles, so that one long
// packet cannot starve the rest. Winners are picked round-robin, starting
// just after the port that was served last.
//
// Ports
//   clock     rising-edge clock for all state
//   reset     asynchronous, active-low reset
//   req       per-port request: the input buffer holds a flit for this output
//   eop       per-port flag: the head flit of that buffer ends its packet
//   credit_i  the downstream port can accept a flit this cycle
//   grant     registered one-hot grant
//   owner     registered index of the granted port
//   busy      high while any grant bit is set
//   xfer      a flit moves this cycle (busy & req[owner] & credit_i)

module router_rr_arbiter #(
    parameter int NPORTS             = 5,
    parameter int INTERLEAVING_GRAIN = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NPORTS-1:0] req,
    input  logic [NPORTS-1:0] eop,
    input  logic              credit_i,
    output logic [NPORTS-1:0] grant,
    output logic [2:0]        owner,
    output logic              busy,
    output logic              xfer
);

    // The grain counter needs to reach INTERLEAVING_GRAIN-1. It is kept at
    // least one bit wide so that a grain of 1 still gives a legal vector.
    // With a grain of 1 the counter stays at zero, and zero is also the
    // expiry value, so a contended grant changes hands every cycle.
    localparam int GW = (INTERLEAVING_GRAIN > 1) ? $clog2(INTERLEAVING_GRAIN) : 1;
    localparam logic [GW-1:0] GRAIN_LAST = GW'(INTERLEAVING_GRAIN - 1);
    localparam logic [2:0]    LAST_RESET = 3'(NPORTS - 1);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t            state_q;
    logic [NPORTS-1:0] grant_q;
    logic [2:0]        owner_q;
    logic [2:0]        last_q;
    logic [GW-1:0]     grainCnt_q;

    logic              ownerReq;
    logic              ownerEop;
    logic [NPORTS-1:0] others;
    logic              anyOther;
    logic              grainHit;
    logic              releaseOwner;
    logic              eopRelease;
    logic [2:0]        idlePick;
    logic [2:0]        nextPick;

    // Round-robin search. The candidates are from+1, from+2, ... modulo
    // NPORTS, and 'from' itself comes last. The loop runs from the farthest
    // candidate to the nearest one, so the final write holds the nearest
    // requester. This avoids a priority chain with early exits.
    function automatic logic [2:0] rrPick(input logic [NPORTS-1:0] r,
                                          input logic [2:0]        from);
        logic [2:0] pick;
        int         p;
        pick = from;
        for (int k = NPORTS; k >= 1; k--) begin
            p = (int'(from) + k) % NPORTS;
            if (|(r & (NPORTS'(1) << p))) begin
                pick = 3'(p);
            end
        end
        return pick;
    endfunction

    function automatic logic [NPORTS-1:0] oneHot(input logic [2:0] idx);
        return NPORTS'(1) << idx;
    endfunction

    // The grant is one-hot. Masking req and eop with it reads the owner's
    // bits without indexing by owner_q, and this stays correct when nothing
    // is granted.
    assign ownerReq = |(grant_q & req);
    assign ownerEop = |(grant_q & eop);
    assign others   = req & ~grant_q;
    assign anyOther = |others;
    assign grainHit = (grainCnt_q == GRAIN_LAST);

    // xfer depends only on the registered grant and on the current inputs.
    // Arbitration therefore never adds a cycle to a flit's path.
    assign busy = |grant_q;
    assign xfer = busy & ownerReq & credit_i;

    // The release causes are ORed together. This gives one re-arbitration
    // per cycle, even when an eop, a dropped request and a grain expiry
    // happen in the same cycle.
    assign eopRelease   = xfer & ownerEop;
    assign releaseOwner = eopRelease | ~ownerReq | (grainHit & anyOther);

    // In IDLE the search starts after the last-served port. When a grant is
    // handed over, the search starts after the current owner, and the owner
    // is already masked out of 'others'.
    assign idlePick = rrPick(req, last_q);
    assign nextPick = rrPick(others, owner_q);

    // Arbiter FSM. A release with another port waiting goes straight to the
    // next owner, so there is no idle bubble. The owner keeps the link only
    // after an eop on a buffer that still holds a request. Grain expiry with
    // nobody waiting restarts the count and does not switch the grant.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            last_q     <= LAST_RESET;
            grainCnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q    <= OWNED;
                        grant_q    <= oneHot(idlePick);
                        owner_q    <= idlePick;
                        last_q     <= idlePick;
                        grainCnt_q <= '0;
                    end
                end
                OWNED: begin
                    if (releaseOwner) begin
                        if (anyOther) begin
                            grant_q    <= oneHot(nextPick);
                            owner_q    <= nextPick;
                            last_q     <= nextPick;
                            grainCnt_q <= '0;
                        end else if (eopRelease) begin
                            grainCnt_q <= '0;
                        end else begin
                            state_q    <= IDLE;
                            grant_q    <= '0;
                            grainCnt_q <= '0;
                        end
                    end else if (grainHit) begin
                        grainCnt_q <= '0;
                    end else begin
                        grainCnt_q <= grainCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_router_rr_arbiter.sv
// tb_router_rr_arbiter
//
// Directed bench for router_rr_arbiter with the default parameters
// (5 ports, grain 10). A behavioural reference model predicts each cycle.
// Its predictions go into a scoreboard queue when the stimulus is driven,
// and they are popped and compared after the clock edge. Fixed expected
// values also cover the documented scenarios.

module tb_router_rr_arbiter;

    localparam int N     = 5;
    localparam int GRAIN = 10;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] eop;
    logic         credit_i;
    logic [N-1:0] grant;
    logic [2:0]   owner;
    logic         busy;
    logic         xfer;

    int checks = 0;
    int errors = 0;

    // Reference model state: holds the link or not, owner, last served, and
    // cycles owned so far.
    bit mBusy;
    int mOwner;
    int mLast;
    int mCnt;

    typedef struct packed {
        logic [N-1:0] grant;
        logic [2:0]   owner;
        logic         busy;
    } exp_t;

    exp_t sbQ[$];

    router_rr_arbiter #(
        .NPORTS(N),
        .INTERLEAVING_GRAIN(GRAIN)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .eop     (eop),
        .credit_i(credit_i),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .xfer    (xfer)
    );

    // 10 ns clock. Inputs change on the falling edge.
    always #5 clock = ~clock;

    // Stop a runaway run with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // The model walks the requesters in round-robin order, from start+1 and
    // wrapping back to start.
    function automatic int searchFrom(input logic [N-1:0] r, input int start);
        int p;
        for (int k = 1; k <= N; k++) begin
            p = (start + k) % N;
            if (r[3'(p)]) return p;
        end
        return start;
    endfunction

    task automatic modelReset();
        mBusy  = 1'b0;
        mOwner = 0;
        mLast  = N - 1;
        mCnt   = 0;
    endtask

    function automatic logic modelXfer(input logic [N-1:0] r, input logic c);
        return mBusy && r[3'(mOwner)] && c;
    endfunction

    // Move the model one clock edge forward, given the inputs seen before it.
    task automatic modelStep(input logic [N-1:0] r, input logic [N-1:0] e, input logic c);
        logic [N-1:0] rest;
        bit oreq, x, oe, hit, rel;
        if (!mBusy) begin
            if (r != '0) begin
                mOwner = searchFrom(r, mLast);
                mLast  = mOwner;
                mBusy  = 1'b1;
                mCnt   = 0;
            end
        end else begin
            oreq = r[3'(mOwner)];
            x    = oreq && c;
            oe   = e[3'(mOwner)];
            rest = r;
            rest[3'(mOwner)] = 1'b0;
            hit  = (mCnt == GRAIN - 1);
            rel  = (x && oe) || !oreq || (hit && rest != '0);
            if (rel) begin
                if (rest != '0) begin
                    mOwner = searchFrom(rest, mOwner);
                    mLast  = mOwner;
                    mCnt   = 0;
                end else if (x && oe) begin
                    mCnt = 0;
                end else begin
                    mBusy = 1'b0;
                end
            end else begin
                mCnt = hit ? 0 : mCnt + 1;
            end
        end
    endtask

    // Pop one prediction and compare the registered outputs with it.
    task automatic checkOutput();
        exp_t ex;
        checkVal("sbDepth", 32'(sbQ.size()), 32'd1);
        if (sbQ.size() > 0) begin
            ex = sbQ.pop_front();
            checkVal("grant", 32'(grant), 32'(ex.grant));
            checkVal("owner", 32'(owner), 32'(ex.owner));
            checkVal("busy", 32'(busy), 32'(ex.busy));
        end
    endtask

    // One cycle: drive on the falling edge, check xfer, predict, clock,
    // then check.
    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] e, input logic c);
        exp_t ex;
        @(negedge clock);
        req      = r;
        eop      = e;
        credit_i = c;
        #1;
        checkVal("xfer", 32'(xfer), 32'(modelXfer(r, c)));
        modelStep(r, e, c);
        ex.busy  = mBusy;
        ex.owner = 3'(mOwner);
        ex.grant = mBusy ? N'(1 << mOwner) : '0;
        sbQ.push_back(ex);
        @(posedge clock);
        #1;
        checkOutput();
    endtask

    // Directed scenarios in order. A short random run with the model as the
    // only reference follows them.
    initial begin
        reset    = 1'b0;
        req      = '0;
        eop      = '0;
        credit_i = 1'b0;
        modelReset();
        #12;
        checkVal("rstGrant", 32'(grant), 32'd0);
        checkVal("rstOwner", 32'(owner), 32'd0);
        checkVal("rstBusy", 32'(busy), 32'd0);
        checkVal("rstXfer", 32'(xfer), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // The first search starts at EAST, so NORTH beats LOCAL.
        applyStimulus(5'b10100, 5'b00000, 1'b1);
        checkVal("firstGrant", 32'(grant), 32'h04);
        checkVal("firstOwner", 32'(owner), 32'd2);
        checkVal("firstBusy", 32'(busy), 32'd1);
        applyStimulus(5'b00000, 5'b00000, 1'b1);
        checkVal("idleAfterDrop", 32'(grant), 32'd0);

        // EAST and WEST share the link and swap every 10 owned cycles.
        for (int i = 0; i < 25; i++) begin
            applyStimulus(5'b00011, 5'b00000, 1'b1);
            checkVal("grainAlt", 32'(grant), ((i / 10) % 2 == 0) ? 32'h01 : 32'h02);
            if (i > 0) checkVal("grainXfer", 32'(xfer), 32'd1);
        end
        applyStimulus(5'b00000, 5'b00000, 1'b1);

        // LOCAL alone keeps the link across several grain periods.
        for (int i = 0; i < 25; i++) begin
            applyStimulus(5'b10000, 5'b00000, 1'b1);
            checkVal("soloLocal", 32'(grant), 32'h10);
        end
        applyStimulus(5'b00000, 5'b00000, 1'b1);

        // SOUTH ends a packet while EAST waits, so EAST gets the link next.
        applyStimulus(5'b01000, 5'b00000, 1'b1);
        checkVal("southWin", 32'(grant), 32'h08);
        applyStimulus(5'b01001, 5'b01000, 1'b1);
        checkVal("eopToEast", 32'(grant), 32'h01);
        applyStimulus(5'b01000, 5'b00000, 1'b1);
        applyStimulus(5'b01000, 5'b01000, 1'b1);
        checkVal("eopRegrant", 32'(grant), 32'h08);
        applyStimulus(5'b00000, 5'b00000, 1'b1);
        checkVal("eopIdle", 32'(grant), 32'd0);

        // With no credit the grain still expires. Nothing moves.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(5'b00101, 5'b00000, 1'b0);
            checkVal("noCreditGrant", 32'(grant), (i < 10) ? 32'h01 : 32'h04);
        end
        applyStimulus(5'b00000, 5'b00000, 1'b1);

        // Reset in the middle of a packet drops the grant without a clock edge.
        applyStimulus(5'b01000, 5'b00000, 1'b1);
        checkVal("preRstGrant", 32'(grant), 32'h08);
        #2;
        reset = 1'b0;
        req   = '0;
        #1;
        modelReset();
        checkVal("asyncGrant", 32'(grant), 32'd0);
        checkVal("asyncBusy", 32'(busy), 32'd0);
        checkVal("asyncOwner", 32'(owner), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(5'b11111, 5'b00000, 1'b1);
        checkVal("postRstEast", 32'(grant), 32'h01);

        // Random traffic checked against the model.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(N'($urandom_range(0, 31)), N'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
